// File: rtl/register_file_scoreboard.sv
// ============================================================================
// Module   : register_file_scoreboard
// Brief    : 2R/1W integer register file with per-register busy scoreboard
//            gating issue on RAW/WAW hazards. Optional same-cycle writeback
//            bypass enabled by defining REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;
    localparam int REGISTER_WIDTH = 32;
endpackage : common

module register_file_scoreboard
    import common::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     rs1_addr,
    input  logic [ADDR_WIDTH-1:0]     rs2_addr,
    output logic [REGISTER_WIDTH-1:0] rs1_value,
    output logic [REGISTER_WIDTH-1:0] rs2_value,
    input  logic                      issue_valid,
    input  logic [ADDR_WIDTH-1:0]     issue_rd,
    output logic                      issue_ready,
    input  logic                      wb_valid,
    input  logic [ADDR_WIDTH-1:0]     wb_rd,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    output logic                      wb_unexpected,
    output logic [ADDR_WIDTH:0]       busy_count
);

    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = '0;

    logic [REGISTER_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       r_busy;
    logic [NUM_REGS-1:0]       w_busy_next;
    logic [ADDR_WIDTH:0]       r_busy_count;
    logic [ADDR_WIDTH:0]       w_busy_count_next;
    logic                      r_wb_unexpected;

    logic                      w_wb_write;
    logic                      w_issue_fire;
    logic                      w_rs1_busy;
    logic                      w_rs2_busy;
    logic                      w_rd_busy;
    logic [REGISTER_WIDTH-1:0] w_rs1_arr;
    logic [REGISTER_WIDTH-1:0] w_rs2_arr;

    assign w_wb_write = wb_valid && (wb_rd != c_zero_addr);

    // ------------------------------------------------------------------------
    // Combinational read ports; x0 is forced to zero regardless of contents.
    // ------------------------------------------------------------------------
    assign w_rs1_arr = (rs1_addr == c_zero_addr) ? '0 : r_regs[rs1_addr];
    assign w_rs2_arr = (rs2_addr == c_zero_addr) ? '0 : r_regs[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    assign rs1_value = (w_wb_write && (wb_rd == rs1_addr)) ? wb_data : w_rs1_arr;
    assign rs2_value = (w_wb_write && (wb_rd == rs2_addr)) ? wb_data : w_rs2_arr;

    // A register being written back this cycle no longer blocks issue.
    assign w_rs1_busy = r_busy[rs1_addr] && (rs1_addr != c_zero_addr)
                        && !(wb_valid && (wb_rd == rs1_addr));
    assign w_rs2_busy = r_busy[rs2_addr] && (rs2_addr != c_zero_addr)
                        && !(wb_valid && (wb_rd == rs2_addr));
    assign w_rd_busy  = r_busy[issue_rd] && (issue_rd != c_zero_addr)
                        && !(wb_valid && (wb_rd == issue_rd));
`else
    assign rs1_value = w_rs1_arr;
    assign rs2_value = w_rs2_arr;

    assign w_rs1_busy = r_busy[rs1_addr] && (rs1_addr != c_zero_addr);
    assign w_rs2_busy = r_busy[rs2_addr] && (rs2_addr != c_zero_addr);
    assign w_rd_busy  = r_busy[issue_rd] && (issue_rd != c_zero_addr);
`endif

    // issue_ready deliberately ignores issue_valid to avoid a comb loop upstream.
    assign issue_ready  = !w_rs1_busy && !w_rs2_busy && !w_rd_busy;
    assign w_issue_fire = issue_valid && issue_ready;

    // ------------------------------------------------------------------------
    // Scoreboard next state: a new claim wins over a same-cycle writeback.
    // ------------------------------------------------------------------------
    assign w_busy_next[0] = 1'b0;

    generate
        for (genvar g_r = 1; g_r < NUM_REGS; g_r++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = w_issue_fire && (issue_rd == ADDR_WIDTH'(g_r));
            assign w_clr = wb_valid && (wb_rd == ADDR_WIDTH'(g_r));
            assign w_busy_next[g_r] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[g_r]);
        end
    endgenerate

    always_comb begin
        w_busy_count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busy_count_next = w_busy_count_next + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy          <= '0;
            r_busy_count    <= '0;
            r_wb_unexpected <= 1'b0;
        end else begin
            r_busy          <= w_busy_next;
            r_busy_count    <= w_busy_count_next;
            r_wb_unexpected <= w_wb_write && !r_busy[wb_rd];
        end
    end

    assign busy_count    = r_busy_count;
    assign wb_unexpected = r_wb_unexpected;

endmodule : register_file_scoreboard

`default_nettype wire

// File: tb/tb_register_file_scoreboard.sv
// ============================================================================
// Module   : tb_register_file_scoreboard
// Brief    : Directed self-checking bench for register_file_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_scoreboard;
    import common::*;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DW         = REGISTER_WIDTH;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [DW-1:0]         rs1_value, rs2_value, wb_data;
    logic                  issue_valid, issue_ready, wb_valid, wb_unexpected;
    logic [ADDR_WIDTH:0]   busy_count;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DW-1:0]         data;
    } wr_t;

    wr_t expq[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    register_file_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_unexpected(wb_unexpected),
        .busy_count   (busy_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pop the oldest expected writeback and check it on read port 1.
    task automatic pop_and_check(input string tag);
        wr_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = expq.pop_front();
            rs1_addr = e.addr;
            #1;
            chk(tag, 64'(rs1_value), 64'(e.data));
        end
    endtask

    task automatic do_wb(input logic [ADDR_WIDTH-1:0] rd, input logic [DW-1:0] d);
        wr_t e;
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        e.addr   = rd;
        e.data   = (rd == '0) ? '0 : d;
        expq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd31; issue_valid = 1'b0;
        issue_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset for two cycles, with a writeback presented that must be ignored.
        tick();
        do_wb(5'd5, 32'hCAFE_0000);
        void'(expq.pop_back());
        tick();
        reset = 1'b0; wb_valid = 1'b0;
        #1;
        chk("reset_rs1",  64'(rs1_value), 64'h0);
        chk("reset_rs2",  64'(rs2_value), 64'h0);
        chk("reset_ready", 64'(issue_ready), 64'h1);
        chk("reset_busy_count", 64'(busy_count), 64'h0);
        chk("reset_wb_unexp", 64'(wb_unexpected), 64'h0);

        // Unexpected writeback to idle x3.
        do_wb(5'd3, 32'hDEAD_BEEF);
        tick();
        wb_valid = 1'b0;
        pop_and_check("wb_x3_read");
        chk("wb_x3_unexp_pulse", 64'(wb_unexpected), 64'h1);
        tick();
        chk("wb_x3_unexp_clear", 64'(wb_unexpected), 64'h0);

        // Claim x7, observe RAW stall, then resolve via writeback.
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("issue7_ready", 64'(issue_ready), 64'h1);
        tick();
        issue_valid = 1'b0; rs1_addr = 5'd7;
        #1;
        chk("issue7_busy_count", 64'(busy_count), 64'h1);
        chk("issue7_raw_stall", 64'(issue_ready), 64'h0);
        do_wb(5'd7, 32'h12);
        #1;
        chk("wb7_same_cycle_value", 64'(rs1_value), c_bypass ? 64'h12 : 64'h0);
        chk("wb7_same_cycle_ready", 64'(issue_ready), c_bypass ? 64'h1 : 64'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("wb7_ready_after", 64'(issue_ready), 64'h1);
        chk("wb7_busy_count", 64'(busy_count), 64'h0);
        chk("wb7_no_unexp", 64'(wb_unexpected), 64'h0);
        pop_and_check("wb7_read");

        // Writes to x0 are discarded and never flagged; claims on x0 are ignored.
        rs1_addr = 5'd0;
        do_wb(5'd0, 32'hFFFF);
        tick();
        wb_valid = 1'b0;
        pop_and_check("x0_read");
        chk("x0_no_unexp", 64'(wb_unexpected), 64'h0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("x0_issue_busy_count", 64'(busy_count), 64'h0);

        // Simultaneous claim and writeback of busy x9.
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("x9_busy_count", 64'(busy_count), 64'h1);
        issue_valid = 1'b1; issue_rd = 5'd9;
        do_wb(5'd9, 32'hA5A5_5A5A);
        #1;
        chk("x9_waw_ready", 64'(issue_ready), c_bypass ? 64'h1 : 64'h0);
        tick();
        issue_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("x9_busy_count_after", 64'(busy_count), c_bypass ? 64'h1 : 64'h0);
        chk("x9_no_unexp", 64'(wb_unexpected), 64'h0);
        pop_and_check("x9_read");
        chk("x9_ready_rs1", 64'(issue_ready), c_bypass ? 64'h0 : 64'h1);

        // Three more claims, then a mid-operation reset drops them all.
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        for (int r = 10; r <= 12; r++) begin
            issue_valid = 1'b1; issue_rd = ADDR_WIDTH'(r);
            tick();
        end
        issue_valid = 1'b0;
        #1;
        chk("three_busy_count", 64'(busy_count), c_bypass ? 64'h4 : 64'h3);
        rs1_addr = 5'd11;
        #1;
        chk("three_raw_stall", 64'(issue_ready), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd7; issue_rd = 5'd11;
        #1;
        chk("rst2_busy_count", 64'(busy_count), 64'h0);
        chk("rst2_ready", 64'(issue_ready), 64'h1);
        chk("rst2_rs1", 64'(rs1_value), 64'h0);
        chk("rst2_rs2", 64'(rs2_value), 64'h0);

        // Writeback to a dropped claim still writes and flags.
        do_wb(5'd11, 32'h55);
        tick();
        wb_valid = 1'b0;
        chk("dropped_unexp", 64'(wb_unexpected), 64'h1);
        pop_and_check("dropped_read");
        chk("dropped_busy_count", 64'(busy_count), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file_scoreboard

`default_nettype wire
